// File: rtl/monitor_pkg.sv
// Shared monitor parameters, the capture-entry layout and the drain FSM encoding.
// Used by the verdict collector and its capture FIFO.
package monitor_pkg;

    localparam int N_OUT   = 3;
    localparam int VALUE_W = 64;
    localparam int TIME_W  = 32;
    localparam int DEPTH   = 8;

    typedef struct packed {
        logic [TIME_W-1:0]             ts;
        logic [N_OUT-1:0]              mask;
        logic [N_OUT-1:0][VALUE_W-1:0] values;
    } entry_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } drain_state_t;

    // Index of the lowest set bit; beats are emitted in ascending stream order.
    function automatic logic [1:0] lowest_set(input logic [N_OUT-1:0] mask);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = N_OUT - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous capture FIFO: storage plus read/write pointers carrying an extra wrap bit.
// Exposes both the head entry and the entry behind it so the drainer can chain entries.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [WIDTH-1:0] next_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [AW:0]      level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      wr_ptr_d;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      rd_ptr_d;
    logic [AW-1:0]    rd_next_idx_s;
    logic             do_push_s;
    logic             do_pop_s;

    // Status flags, read ports and pointer advance.
    always_comb begin
        empty_o       = (wr_ptr_q == rd_ptr_q);
        full_o        = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        level_o       = wr_ptr_q - rd_ptr_q;
        do_push_s     = push_i & ~full_o;
        do_pop_s      = pop_i & ~empty_o;
        rd_next_idx_s = rd_ptr_q[AW-1:0] + AW'(1);
        head_o        = mem_q[rd_ptr_q[AW-1:0]];
        next_o        = mem_q[rd_next_idx_s];
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + (AW + 1)'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + (AW + 1)'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/verdict_collector.sv
// Captures monitor stream outputs with a timestamp into a FIFO and drains each entry
// as one ready/valid beat per active stream, lowest stream index first.
module verdict_collector #(
    parameter int N_OUT   = monitor_pkg::N_OUT,
    parameter int VALUE_W = monitor_pkg::VALUE_W,
    parameter int TIME_W  = monitor_pkg::TIME_W,
    parameter int DEPTH   = monitor_pkg::DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic signed [VALUE_W-1:0] output_0,
    input  logic signed [VALUE_W-1:0] output_1,
    input  logic signed [VALUE_W-1:0] output_2,
    input  logic                      output_0_aktv,
    input  logic                      output_1_aktv,
    input  logic                      output_2_aktv,
    output logic                      rec_valid,
    input  logic                      rec_ready,
    output logic [1:0]                rec_id,
    output logic signed [VALUE_W-1:0] rec_value,
    output logic [TIME_W-1:0]         rec_time,
    output logic                      rec_last,
    output logic                      overflow,
    output logic [15:0]               drop_count,
    output logic [$clog2(DEPTH):0]    level
);

    import monitor_pkg::entry_t;
    import monitor_pkg::drain_state_t;
    import monitor_pkg::ST_IDLE;
    import monitor_pkg::ST_EMIT;
    import monitor_pkg::lowest_set;

    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [TIME_W-1:0]  ts_q;
    logic [TIME_W-1:0]  ts_d;
    logic [N_OUT-1:0]   mask_s;
    logic               capture_s;
    logic               push_s;
    logic               drop_s;
    logic               pop_s;
    logic               overflow_q;
    logic               overflow_d;
    logic [15:0]        drops_q;
    logic [15:0]        drops_d;

    entry_t             cap_s;
    entry_t             head_s;
    entry_t             nxt_s;
    entry_t             load_s;
    logic               empty_s;
    logic               full_s;
    logic [LVL_W-1:0]   level_s;

    drain_state_t       state_q;
    drain_state_t       state_d;
    entry_t             ent_q;
    entry_t             ent_d;
    logic [N_OUT-1:0]   rem_q;
    logic [N_OUT-1:0]   rem_d;
    logic               valid_q;
    logic               valid_d;
    logic               last_q;
    logic               last_d;
    logic [1:0]         id_q;
    logic [1:0]         id_d;
    logic [VALUE_W-1:0] value_q;
    logic [VALUE_W-1:0] value_d;
    logic [TIME_W-1:0]  time_q;
    logic [TIME_W-1:0]  time_d;

    logic               has_next_s;
    logic               load_go_s;
    logic [1:0]         ld_idx_s;
    logic [N_OUT-1:0]   ld_rem_s;
    logic [1:0]         st_idx_s;
    logic [N_OUT-1:0]   st_rem_s;

    // Capture decision, timestamp advance and drop accounting.
    always_comb begin
        mask_s      = {output_2_aktv, output_1_aktv, output_0_aktv};
        capture_s   = en & (|mask_s);
        push_s      = capture_s & ~full_s;
        drop_s      = capture_s & full_s;
        cap_s.ts     = ts_q;
        cap_s.mask   = mask_s;
        cap_s.values = {output_2, output_1, output_0};
        if (en) begin
            ts_d = ts_q + TIME_W'(1);
        end else begin
            ts_d = ts_q;
        end
        overflow_d = overflow_q | drop_s;
        if (drop_s && (drops_q != 16'hFFFF)) begin
            drops_d = drops_q + 16'd1;
        end else begin
            drops_d = drops_q;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_s),
        .wdata_i (cap_s),
        .pop_i   (pop_s),
        .head_o  (head_s),
        .next_o  (nxt_s),
        .empty_o (empty_s),
        .full_o  (full_s),
        .level_o (level_s)
    );

    // Pick the entry to load: FIFO head from IDLE; on a pop, the entry behind the
    // head, or the one being captured right now when the head was the only entry.
    always_comb begin
        has_next_s = (level_s > LVL_W'(1)) | push_s;
        if (state_q == ST_IDLE) begin
            load_s = head_s;
        end else if (level_s > LVL_W'(1)) begin
            load_s = nxt_s;
        end else begin
            load_s = cap_s;
        end
        ld_idx_s = lowest_set(load_s.mask);
        ld_rem_s = load_s.mask & ~(N_OUT'(1) << ld_idx_s);
        st_idx_s = lowest_set(rem_q);
        st_rem_s = rem_q & ~(N_OUT'(1) << st_idx_s);
    end

    // Drain FSM next state and registered beat fields.
    always_comb begin
        state_d   = state_q;
        ent_d     = ent_q;
        rem_d     = rem_q;
        valid_d   = valid_q;
        last_d    = last_q;
        id_d      = id_q;
        value_d   = value_q;
        time_d    = time_q;
        pop_s     = 1'b0;
        load_go_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty_s) begin
                    load_go_s = 1'b1;
                end else begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end
            end
            ST_EMIT: begin
                if (rec_ready && last_q) begin
                    pop_s = 1'b1;
                    if (has_next_s) begin
                        load_go_s = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end
                end else if (rec_ready) begin
                    id_d    = st_idx_s;
                    value_d = ent_q.values[st_idx_s];
                    rem_d   = st_rem_s;
                    last_d  = (st_rem_s == '0);
                end else begin
                    valid_d = valid_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
        if (load_go_s) begin
            state_d = ST_EMIT;
            ent_d   = load_s;
            rem_d   = ld_rem_s;
            valid_d = 1'b1;
            id_d    = ld_idx_s;
            value_d = load_s.values[ld_idx_s];
            time_d  = load_s.ts;
            last_d  = (ld_rem_s == '0);
        end else begin
            ent_d = ent_d;
        end
    end

    // State, timestamp and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ts_q       <= '0;
            overflow_q <= 1'b0;
            drops_q    <= 16'd0;
            state_q    <= ST_IDLE;
            ent_q      <= '0;
            rem_q      <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            id_q       <= 2'd0;
            value_q    <= '0;
            time_q     <= '0;
        end else begin
            ts_q       <= ts_d;
            overflow_q <= overflow_d;
            drops_q    <= drops_d;
            state_q    <= state_d;
            ent_q      <= ent_d;
            rem_q      <= rem_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            id_q       <= id_d;
            value_q    <= value_d;
            time_q     <= time_d;
        end
    end

    assign rec_valid  = valid_q;
    assign rec_id     = id_q;
    assign rec_value  = $signed(value_q);
    assign rec_time   = time_q;
    assign rec_last   = last_q;
    assign overflow   = overflow_q;
    assign drop_count = drops_q;
    assign level      = level_s;

endmodule

// File: tb/tb_verdict_collector.sv
// Randomised and directed bench for verdict_collector, checked against a
// beat-queue reference model built from the capture/drain rules.
module tb_verdict_collector;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic signed [63:0] out0;
    logic signed [63:0] out1;
    logic signed [63:0] out2;
    logic               ak0;
    logic               ak1;
    logic               ak2;
    logic               rec_valid;
    logic               rec_ready;
    logic [1:0]         rec_id;
    logic signed [63:0] rec_value;
    logic [31:0]        rec_time;
    logic               rec_last;
    logic               overflow;
    logic [15:0]        drop_count;
    logic [3:0]         level;

    always #5 clk = ~clk;

    verdict_collector dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .output_0      (out0),
        .output_1      (out1),
        .output_2      (out2),
        .output_0_aktv (ak0),
        .output_1_aktv (ak1),
        .output_2_aktv (ak2),
        .rec_valid     (rec_valid),
        .rec_ready     (rec_ready),
        .rec_id        (rec_id),
        .rec_value     (rec_value),
        .rec_time      (rec_time),
        .rec_last      (rec_last),
        .overflow      (overflow),
        .drop_count    (drop_count),
        .level         (level)
    );

    typedef struct {
        logic [1:0]  id;
        logic [63:0] val;
        logic [31:0] ts;
        logic        last;
    } beat_t;

    beat_t       beats[$];
    int          lvl;
    int          lvl_prev;
    logic [31:0] m_cnt;
    logic        m_ovf;
    int          m_drops;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // A beat is on the bus whenever entries are buffered and the FIFO was not
    // empty in the previous cycle (one cycle of capture-to-valid latency).
    task automatic check_outputs();
        logic exp_valid;
        exp_valid = (lvl > 0) && (lvl_prev > 0);
        chk_eq("level", 64'(level), 64'(lvl));
        chk_eq("overflow", 64'(overflow), 64'(m_ovf));
        chk_eq("drop_count", 64'(drop_count), 64'(m_drops));
        chk_eq("rec_valid", 64'(rec_valid), 64'(exp_valid));
        if (exp_valid) begin
            chk_eq("rec_id", 64'(rec_id), 64'(beats[0].id));
            chk_eq("rec_value", rec_value, beats[0].val);
            chk_eq("rec_time", 64'(rec_time), 64'(beats[0].ts));
            chk_eq("rec_last", 64'(rec_last), 64'(beats[0].last));
        end else begin
            chk_eq("rec_last_idle", 64'(rec_last), 64'd0);
        end
    endtask

    task automatic model_edge(input logic r, input logic e, input logic [2:0] a,
                              input logic [63:0] x0, input logic [63:0] x1,
                              input logic [63:0] x2, input logic rdy);
        int          nl;
        logic [63:0] xs[3];
        if (!r) begin
            beats.delete();
            lvl      = 0;
            lvl_prev = 0;
            m_cnt    = 32'd0;
            m_ovf    = 1'b0;
            m_drops  = 0;
            return;
        end
        xs[0] = x0;
        xs[1] = x1;
        xs[2] = x2;
        nl = lvl;
        if ((lvl > 0) && (lvl_prev > 0) && rdy) begin
            if (beats[0].last) nl--;
            beats.delete(0);
        end
        if (e && (a != 3'b000)) begin
            if (lvl == 8) begin
                m_ovf = 1'b1;
                if (m_drops < 65535) m_drops++;
            end else begin
                nl++;
                for (int i = 0; i < 3; i++) begin
                    if (a[i]) begin
                        beats.push_back('{id: 2'(i), val: xs[i], ts: m_cnt,
                                          last: ((a >> (i + 1)) == 3'd0)});
                    end
                end
            end
        end
        if (e) m_cnt = m_cnt + 32'd1;
        lvl_prev = lvl;
        lvl      = nl;
    endtask

    task automatic step(input logic r, input logic e, input logic [2:0] a,
                        input logic [63:0] x0, input logic [63:0] x1,
                        input logic [63:0] x2, input logic rdy);
        check_outputs();
        rst       = r;
        en        = e;
        ak0       = a[0];
        ak1       = a[1];
        ak2       = a[2];
        out0      = x0;
        out1      = x1;
        out2      = x2;
        rec_ready = rdy;
        @(posedge clk);
        model_edge(r, e, a, x0, x1, x2, rdy);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic e, input logic rdy);
        repeat (n) step(1'b1, e, 3'b000, 64'd0, 64'd0, 64'd0, rdy);
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; rec_ready = 1'b0;
        ak0 = 1'b0; ak1 = 1'b0; ak2 = 1'b0;
        out0 = '0; out1 = '0; out2 = '0;
        repeat (2) @(posedge clk);
        model_edge(1'b0, 1'b0, 3'b000, 64'd0, 64'd0, 64'd0, 1'b0);
        @(negedge clk);
        chk_eq("reset_rec_id", 64'(rec_id), 64'd0);
        chk_eq("reset_rec_value", rec_value, 64'd0);
        chk_eq("reset_rec_time", 64'(rec_time), 64'd0);
        chk_eq("reset_rec_valid", 64'(rec_valid), 64'd0);
        chk_eq("reset_level", 64'(level), 64'd0);

        // Single capture at counter 5 with mask 101.
        idle(5, 1'b1, 1'b1);
        step(1'b1, 1'b1, 3'b101, 64'd10, 64'd0, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1);
        chk_eq("t032_level_after_cap", 64'(level), 64'd1);
        chk_eq("t032_no_valid_yet", 64'(rec_valid), 64'd0);
        idle(1, 1'b1, 1'b1);
        chk_eq("t032_b0_id", 64'(rec_id), 64'd0);
        chk_eq("t032_b0_value", rec_value, 64'd10);
        chk_eq("t032_b0_time", 64'(rec_time), 64'd5);
        chk_eq("t032_b0_last", 64'(rec_last), 64'd0);
        idle(1, 1'b1, 1'b1);
        chk_eq("t032_b1_id", 64'(rec_id), 64'd2);
        chk_eq("t032_b1_value", rec_value, 64'hFFFF_FFFF_FFFF_FFFD);
        chk_eq("t032_b1_last", 64'(rec_last), 64'd1);
        idle(1, 1'b1, 1'b1);
        chk_eq("t032_level_end", 64'(level), 64'd0);

        // Backpressure for 4 cycles with an entry pending.
        step(1'b1, 1'b1, 3'b011, 64'd77, 64'd88, 64'd0, 1'b0);
        idle(5, 1'b1, 1'b0);
        chk_eq("t033_valid_held", 64'(rec_valid), 64'd1);
        idle(4, 1'b1, 1'b1);

        // Overflow: ten captures without draining.
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b1, 3'b001, 64'(100 + i), 64'd0, 64'd0, 1'b0);
        chk_eq("t034_level", 64'(level), 64'd8);
        chk_eq("t034_overflow", 64'(overflow), 64'd1);
        chk_eq("t034_drops", 64'(drop_count), 64'd2);
        idle(12, 1'b1, 1'b1);

        // Enable gating: active streams while disabled never capture.
        repeat (3) step(1'b1, 1'b0, 3'b111, 64'd1, 64'd2, 64'd3, 1'b1);
        chk_eq("t035_no_capture", 64'(level), 64'd0);
        step(1'b1, 1'b1, 3'b111, 64'd4, 64'd5, 64'd6, 1'b1);
        idle(5, 1'b1, 1'b1);

        // Timestamp wrap across 0xFFFFFFFF.
        force dut.ts_q = 32'hFFFF_FFFF;
        m_cnt = 32'hFFFF_FFFF;
        idle(1, 1'b0, 1'b1);
        release dut.ts_q;
        step(1'b1, 1'b1, 3'b001, 64'h11, 64'd0, 64'd0, 1'b1);
        step(1'b1, 1'b1, 3'b001, 64'h22, 64'd0, 64'd0, 1'b1);
        chk_eq("t036_time_max", 64'(rec_time), 64'hFFFF_FFFF);
        idle(1, 1'b1, 1'b1);
        chk_eq("t036_time_zero", 64'(rec_time), 64'd0);
        idle(3, 1'b1, 1'b1);

        // Reset in the middle of draining three entries.
        repeat (3) step(1'b1, 1'b1, 3'b110, 64'd9, 64'd8, 64'd7, 1'b0);
        idle(1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 3'b111, 64'd1, 64'd1, 64'd1, 1'b1);
        chk_eq("t037_level", 64'(level), 64'd0);
        chk_eq("t037_valid", 64'(rec_valid), 64'd0);
        idle(2, 1'b1, 1'b1);

        // Random traffic.
        for (int c = 0; c < 2000; c++) begin
            logic        r;
            logic        e;
            logic [2:0]  a;
            logic        rdy;
            r   = ($urandom_range(199) != 0);
            e   = ($urandom_range(9) < 8);
            a   = 3'($urandom_range(7));
            rdy = ($urandom_range(9) < 6);
            step(r, e, a, {$urandom, $urandom}, {$urandom, $urandom},
                 {$urandom, $urandom}, rdy);
        end
        idle(30, 1'b0, 1'b1);
        check_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/verdict_collector.md
VERDICT_COLLECTOR -- requirements
Module: verdict_collector

Interface
REQ-001 Parameters SHALL be: N_OUT, default 3, number of monitor output streams; VALUE_W, default 64, signed stream value width; TIME_W, default 32, timestamp width; DEPTH, default 8, capture FIFO entries (power of two).
REQ-002 clk  in  1  sole clock, all logic on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-low (0 = reset).
REQ-004 en  in  1  global enable, same meaning as on the monitor.
REQ-005 output_<i>  in  VALUE_W  signed stream value from monitor, i = 0..N_OUT-1.
REQ-006 output_<i>_aktv  in  1  stream i produced a value this cycle.
REQ-007 rec_valid  out  1  record beat available.
REQ-008 rec_ready  in  1  consumer accepts beat when rec_valid and rec_ready are both high.
REQ-009 rec_id  out  2  stream index of current beat.
REQ-010 rec_value  out  VALUE_W  captured stream value.
REQ-011 rec_time  out  TIME_W  capture timestamp.
REQ-012 rec_last  out  1  final beat of the current entry.
REQ-013 overflow  out  1  sticky: at least one entry dropped.
REQ-014 drop_count  out  16  dropped entries, saturating at 0xFFFF.
REQ-015 level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-016 Free-running timestamp counter SHALL increment by 1 each cycle with en=1, hold when en=0, and wrap from 2^TIME_W-1 to 0.
REQ-017 Capture: in a cycle with en=1 and any aktv=1, one entry {timestamp, aktv mask, all N_OUT values} SHALL be pushed; the timestamp is the counter value in that cycle, before increment.
REQ-018 Cycles with en=0 SHALL never capture, regardless of aktv.
REQ-019 Capture while level==DEPTH SHALL drop the entry, set overflow, and increment drop_count (saturating); no pop in the same cycle frees a slot for it.
REQ-020 Drain FSM states SHALL be IDLE (FIFO empty, rec_valid=0) and EMIT (rec_valid=1, presenting head entry).
REQ-021 IDLE->EMIT SHALL occur on the cycle after the FIFO becomes non-empty; capture-to-rec_valid latency is exactly 1 cycle.
REQ-022 In EMIT, one beat SHALL be presented per set mask bit, in ascending stream index; rec_id, rec_value, rec_time, rec_last SHALL hold stable while rec_valid=1 and rec_ready=0.
REQ-023 rec_last SHALL be 1 exactly on the highest set mask bit; its handshake pops the entry.
REQ-024 After a pop, the FSM SHALL go to EMIT with the next entry in the following cycle if the FIFO is non-empty, else to IDLE; back-to-back beats SHALL sustain one beat per cycle with rec_ready held high.
REQ-025 Simultaneous push and pop SHALL leave level unchanged and both SHALL take effect.
REQ-026 Draining SHALL continue while en=0.
REQ-027 Pointer wrap SHALL be modulo DEPTH with an extra wrap bit to distinguish full from empty.

Reset
REQ-028 While rst=0 at a rising edge: counter=0, FIFO empty, level=0, FSM=IDLE, rec_valid=0, rec_last=0, rec_id=0, rec_value=0, rec_time=0, overflow=0, drop_count=0.
REQ-029 Reset mid-transfer SHALL discard all buffered entries and any partially emitted entry; no beat is presented in the cycle after reset release.

Structure
REQ-030 Shared package monitor_pkg SHALL hold N_OUT, VALUE_W, TIME_W, DEPTH and the capture-entry struct typedef (time, mask, value array).
REQ-031 FIFO storage and pointers SHALL be one sub-module, sync_fifo; capture logic, timestamp counter and drain FSM stay in verdict_collector.

Verification
REQ-032 Reset then single capture: at counter=5, aktv=3'b101, values (10,0,-3), rec_ready=1 -> beats (id0,10,t5,last0) then (id2,-3,t5,last1), level returns to 0.
REQ-033 Backpressure: rec_ready=0 for 4 cycles with entry pending -> rec_valid=1 and outputs stable for all 4 cycles, then beat accepted on the first cycle with rec_ready=1.
REQ-034 Overflow: rec_ready=0, 10 consecutive captures -> level=8, overflow=1, drop_count=2; drained timestamps are those of the first 8 captures.
REQ-035 en gating: aktv=3'b111 with en=0 for 3 cycles -> no capture, counter unchanged; en=1 next cycle -> one capture with the held counter value.
REQ-036 Wrap: preload counter near 2^32-1, capture at 0xFFFFFFFF and on the next cycle -> rec_time 0xFFFFFFFF then 0x00000000.
REQ-037 Reset mid-drain: rst=0 for 1 cycle during EMIT with 3 entries buffered -> level=0, rec_valid=0, no stale beat after release.
